// File: rtl/layer_sequencer.sv
// Inference layer scheduler: launches each layer engine in index order and routes the active
// engine's writes onto the shared temp-RAM port. Define SEQ_WATCHDOG_EN to add the per-stage watchdog.

module layer_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          run,
    input  logic [NUM_STAGES-1:0]         stage_ready,
    input  logic [NUM_STAGES*ADDR_W-1:0]  st_addr,
    input  logic [NUM_STAGES*DATA_W-1:0]  st_data,
    input  logic [NUM_STAGES-1:0]         st_wren,
    output logic [NUM_STAGES-1:0]         stage_start,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic signed [DATA_W-1:0]      mem_data,
    output logic                          mem_wren,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [31:0]                   run_cycles
);

    localparam int STAGE_W = $clog2(NUM_STAGES);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_reg, state_next;
    logic [STAGE_W-1:0] stage_reg, stage_next;
    logic [31:0]        cycle_cnt_reg;
    logic [31:0]        run_cycles_reg;
    logic               busy_reg;
    logic               run_accept;
    logic               route_en;
    logic               counting;
    logic               timeout_hit;

    logic [ADDR_W-1:0]  addr_slice [NUM_STAGES];
    logic [DATA_W-1:0]  data_slice [NUM_STAGES];

    assign run_accept = (state_reg == S_IDLE) && run;
    assign route_en   = (state_reg == S_LAUNCH) || (state_reg == S_WAIT);
    assign counting   = (state_reg == S_LAUNCH) || (state_reg == S_WAIT) ||
                        (state_reg == S_ADVANCE);

    // Unpack the engine buses and decode the one-hot launch strobe per engine
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign addr_slice[gi]  = st_addr[gi*ADDR_W +: ADDR_W];
            assign data_slice[gi]  = st_data[gi*DATA_W +: DATA_W];
            assign stage_start[gi] = (state_reg == S_LAUNCH) && (stage_reg == STAGE_W'(gi));
        end
    endgenerate

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            error_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == S_LAUNCH) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == S_WAIT) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    // Fires on the last permitted WAIT cycle, so ERROR follows exactly TIMEOUT_CYCLES WAIT cycles
    assign timeout_hit = (state_reg == S_WAIT) &&
                         (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            error_reg <= 1'b0;
        end else if (run_accept) begin
            error_reg <= 1'b0;
        end else if (state_next == S_ERROR) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
            stage_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            busy_reg  <= (state_next == S_LAUNCH) || (state_next == S_WAIT) ||
                         (state_next == S_ADVANCE) || (state_next == S_DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_LAUNCH;
                    stage_next = '0;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (stage_ready[stage_reg]) begin
                    state_next = S_ADVANCE;
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end
            end
            S_ADVANCE: begin
                if (stage_reg == LAST_STAGE) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_LAUNCH;
                    stage_next = stage_reg + 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Saturating run-length counter; only a clean completion publishes it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_reg  <= '0;
            run_cycles_reg <= '0;
        end else begin
            if (run_accept) begin
                cycle_cnt_reg <= '0;
            end else if (counting && (cycle_cnt_reg != 32'hFFFF_FFFF)) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end
            if (state_reg == S_DONE) begin
                run_cycles_reg <= cycle_cnt_reg;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (route_en) begin
            mem_addr = addr_slice[stage_reg];
            mem_data = signed'(data_slice[stage_reg]);
            mem_wren = st_wren[stage_reg];
        end
    end

    assign cur_stage  = stage_reg;
    assign busy       = busy_reg;
    assign done       = (state_reg == S_DONE);
    assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a timeline model predicts every output per cycle.
// Watchdog scenarios are compiled in only when SEQ_WATCHDOG_EN is defined.

module tb_layer_sequencer;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int TO = 100;
    localparam int SW = $clog2(N);

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            run = 1'b0;
    logic [N-1:0]    stage_ready = '0;
    logic [N*AW-1:0] st_addr = '0;
    logic [N*DW-1:0] st_data = '0;
    logic [N-1:0]    st_wren = '0;
    logic [N-1:0]    stage_start;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_wren;
    logic [SW-1:0]   cur_stage;
    logic            busy;
    logic            done;
    logic            error;
    logic [31:0]     run_cycles;

    layer_sequencer #(
        .NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .run(run), .stage_ready(stage_ready),
        .st_addr(st_addr), .st_data(st_data), .st_wren(st_wren),
        .stage_start(stage_start), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .cur_stage(cur_stage), .busy(busy), .done(done),
        .error(error), .run_cycles(run_cycles)
    );

    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_run_cycles = '0;
    logic        exp_error = 1'b0;
    int          exp_idle_stage = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < N; k++) begin
            st_addr[k*AW +: AW] = AW'($urandom);
            st_data[k*DW +: DW] = $urandom;
        end
        st_wren = N'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_start"}, stage_start, '0);
        check_eq({tag, "_addr"}, mem_addr, '0);
        check_eq({tag, "_data"}, mem_data, '0);
        check_eq({tag, "_wren"}, mem_wren, 1'b0);
    endtask

    task automatic check_idle();
        check_quiet("idle");
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_done", done, 1'b0);
        check_eq("idle_error", error, exp_error);
        check_eq("idle_stage", cur_stage, exp_idle_stage);
        check_eq("idle_run_cycles", run_cycles, exp_run_cycles);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            run = 1'b0;
            drive_bus();
            stage_ready = N'($urandom);
            #1;
            check_idle();
        end
    endtask

    // One cycle inside stage k: launch, wait (ready_now completes the stage) or advance
    task automatic step(input int k, input bit launch, input bit active, input bit in_wait,
                        input bit ready_now, input bit noise, input bit directed);
        logic [N-1:0]  exp_ss;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_wren;
        @(posedge Clk); #1;
        run = noise ? 1'($urandom) : 1'b0;
        drive_bus();
        if (directed && k == 1 && active) begin
            st_addr[1*AW +: AW] = 14'h0123;
            st_data[1*DW +: DW] = 32'hFFFF_FFFB;
            st_wren[1]          = 1'b1;
            st_addr[2*AW +: AW] = 14'h3FFF;
            st_wren[2]          = 1'b1;
        end
        stage_ready = noise ? N'($urandom) : '0;
        if (in_wait) stage_ready[k] = ready_now;
        #1;
        exp_ss = '0;
        if (launch) exp_ss[k] = 1'b1;
        exp_addr = active ? st_addr[k*AW +: AW] : '0;
        exp_data = active ? st_data[k*DW +: DW] : '0;
        exp_wren = active ? st_wren[k] : 1'b0;
        check_eq("stage_start", stage_start, exp_ss);
        check_eq("busy", busy, 1'b1);
        check_eq("done_early", done, 1'b0);
        check_eq("cur_stage", cur_stage, k);
        check_eq("error_run", error, exp_error);
        check_eq("mem_addr", mem_addr, exp_addr);
        check_eq("mem_data", mem_data, exp_data);
        check_eq("mem_wren", mem_wren, exp_wren);
        if (directed && k == 1 && active) begin
            check_eq("route_addr_0123", mem_addr, 14'h0123);
            check_eq("route_data_m5", mem_data, 32'hFFFF_FFFB);
            check_eq("route_wren", mem_wren, 1'b1);
        end
    endtask

    task automatic do_abort();
        #1 Reset = 1'b0;
        #1;
        check_quiet("rst");
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_stage", cur_stage, 0);
        check_eq("rst_run_cycles", run_cycles, 32'd0);
        run = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_hold_done", done, 1'b0);
        check_eq("rst_hold_start", stage_start, '0);
        #1 Reset = 1'b1;
        exp_run_cycles = '0;
        exp_error      = 1'b0;
        exp_idle_stage = 0;
    endtask

    // Stage k occupies 1 LAUNCH + (d[k]+1) WAIT + 1 ADVANCE cycles; DONE follows the last stage
    task automatic do_run(input int d[N], input bit noise, input bit directed,
                          input int abort_stage, input int hang_stage, input bit hold_run,
                          input string name);
        int total = 0;
        @(posedge Clk); #1;
        run = 1'b1;
        drive_bus();
        stage_ready = noise ? N'($urandom) : '0;
        #1;
        check_idle();
        exp_error = 1'b0;
        for (int k = 0; k < N; k++) begin
            step(k, 1'b1, 1'b1, 1'b0, 1'b0, noise, directed);
            if (k == hang_stage) begin
                for (int w = 0; w < TO; w++) step(k, 1'b0, 1'b1, 1'b1, 1'b0, noise, 1'b0);
                @(posedge Clk); #1;
                run = 1'b0;
                drive_bus();
                stage_ready = N'($urandom);
                stage_ready[k] = 1'b0;
                #1;
                check_quiet("err");
                check_eq("err_error", error, 1'b1);
                check_eq("err_busy", busy, 1'b0);
                check_eq("err_done", done, 1'b0);
                check_eq("err_stage", cur_stage, k);
                check_eq("err_run_cycles", run_cycles, exp_run_cycles);
                exp_error      = 1'b1;
                exp_idle_stage = k;
                $display("[TB] run %s: watchdog abort in stage %0d", name, k);
                return;
            end
            for (int w = 0; w <= d[k]; w++) begin
                step(k, 1'b0, 1'b1, 1'b1, (w == d[k]), noise, directed);
                if (k == abort_stage && w == 0) begin
                    do_abort();
                    $display("[TB] run %s: reset during stage %0d wait", name, k);
                    return;
                end
            end
            step(k, 1'b0, 1'b0, 1'b0, 1'b0, noise, 1'b0);
            total += 3 + d[k];
        end
        @(posedge Clk); #1;
        run = hold_run ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
        drive_bus();
        stage_ready = noise ? N'($urandom) : '0;
        #1;
        check_quiet("done");
        check_eq("done_pulse", done, 1'b1);
        check_eq("done_busy", busy, 1'b1);
        check_eq("done_error", error, 1'b0);
        check_eq("done_run_cycles_old", run_cycles, exp_run_cycles);
        exp_run_cycles = total;
        exp_idle_stage = N - 1;
        $display("[TB] run %s: done, expected run_cycles %0d", name, total);
    endtask

    initial begin
        int  dl[N];
        bit  hold;

        repeat (2) @(posedge Clk);
        #1;
        check_quiet("reset");
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_error", error, 1'b0);
        check_eq("reset_stage", cur_stage, 0);
        check_eq("reset_run_cycles", run_cycles, 32'd0);
        #1 Reset = 1'b1;
        idle_cycles(3);

        dl = '{10, 20, 5, 7};
        do_run(dl, 1'b0, 1'b1, -1, -1, 1'b0, "plan");
        idle_cycles(2);
        check_eq("run_cycles_54", run_cycles, 32'd54);

        do_run(dl, 1'b1, 1'b0, -1, -1, 1'b0, "plan_noise");
        idle_cycles(2);
        check_eq("run_cycles_54_noise", run_cycles, 32'd54);

        dl = '{0, 0, 0, 0};
        do_run(dl, 1'b1, 1'b0, -1, -1, 1'b0, "minimum");
        idle_cycles(1);
        check_eq("run_cycles_min", run_cycles, 32'd12);

        dl = '{2, 1, 3, 0};
        do_run(dl, 1'b1, 1'b0, -1, -1, 1'b1, "held_run");
        dl = '{1, 4, 0, 2};
        do_run(dl, 1'b0, 1'b0, -1, -1, 1'b0, "back_to_back");
        idle_cycles(2);

        dl = '{3, 4, 6, 2};
        do_run(dl, 1'b1, 1'b0, 2, -1, 1'b0, "abort");
        idle_cycles(3);
        do_run(dl, 1'b0, 1'b0, -1, -1, 1'b0, "after_abort");
        idle_cycles(1);

        hold = 1'b0;
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) dl[k] = int'($urandom_range(0, 12));
            if (!hold) idle_cycles(int'($urandom_range(1, 3)));
            hold = ($urandom_range(0, 2) == 0);
            do_run(dl, 1'($urandom), 1'b0, -1, -1, hold, $sformatf("rand%0d", r));
        end
        idle_cycles(2);

`ifdef SEQ_WATCHDOG_EN
        dl = '{1, 0, 2, 3};
        do_run(dl, 1'b0, 1'b0, -1, 1, 1'b0, "hang");
        idle_cycles(3);
        do_run(dl, 1'b0, 1'b0, -1, -1, 1'b0, "after_hang");
        idle_cycles(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
